toeplitz_outbuf: RTL and testbench

- Output stage directly downstream of the Toeplitz extractor.
- Captures each L-bit extracted word on the extractor's one-cycle `qstrobe` pulse and queues it in a DEPTH-word FIFO.
- Emits each word as L/W chunks of W bits over a valid/ready stream.
- The extractor cannot be back-pressured, so overflow drops whole words and counts them.

---
 rtl/toeplitz_outbuf_if.sv | 22 ++
 rtl/toeplitz_outbuf.sv | 148 ++++++++++++++
 tb/tb_toeplitz_outbuf.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toeplitz_outbuf_if.sv
// rtl/toeplitz_outbuf_if.sv - extractor word input and chunk output stream bundle
interface toeplitz_outbuf_if #(
  parameter int L = 128,
  parameter int W = 8
) ();
  logic [L-1:0] q;
  logic         qstrobe;
  logic [W-1:0] dout;
  logic         dvalid;
  logic         dready;
  logic         dlast;

  modport master (
    input  q, qstrobe, dready,
    output dout, dvalid, dlast
  );

  modport slave (
    output q, qstrobe, dready,
    input  dout, dvalid, dlast
  );
endinterface

// File: rtl/toeplitz_outbuf.sv
// rtl/toeplitz_outbuf.sv - word FIFO plus LSB-first chunk serializer behind the Toeplitz extractor
module toeplitz_outbuf #(
  parameter int L     = 128,
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  toeplitz_outbuf_if.master          bus,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [CW-1:0]              drop_cnt,
  input  logic                       clear_ovf
);
  localparam int NCH = L / W;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW  = $clog2(DEPTH + 1);
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [LW-1:0] FULL     = LW'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  generate
    if ((L % W) != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
      $error("toeplitz_outbuf: illegal L, W or DEPTH");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t          state_q, state_d;
  logic [L-1:0]    sreg_q, sreg_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    dout_q, dout_d;
  logic            dvalid_q, dvalid_d;
  logic            dlast_q, dlast_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [L-1:0]    fifo_q [DEPTH];
  logic [L-1:0]    fifo_d [DEPTH];

  logic            xfer;
  logic            pop;
  logic            push;
  logic            drop;

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    idx_d      = idx_q;
    pop        = 1'b0;
    xfer       = dvalid_q & bus.dready;

    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          sreg_d  = fifo_q[rd_ptr_q];
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (idx_q != LAST_IDX) begin
            sreg_d = sreg_q >> W;
            idx_d  = idx_q + IW'(1);
          end else if (level_q != '0) begin
            // Reload straight from the FIFO so consecutive words leave no gap.
            pop    = 1'b1;
            sreg_d = fifo_q[rd_ptr_q];
            idx_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    push = bus.qstrobe & ((level_q != FULL) | pop);
    drop = bus.qstrobe & ~push;

    fifo_d = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = bus.q;
    end
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);

    if (clear_ovf) begin
      overflow_d = drop;
      drop_cnt_d = drop ? CW'(1) : '0;
    end else begin
      overflow_d = overflow_q | drop;
      drop_cnt_d = (drop && !(&drop_cnt_q)) ? drop_cnt_q + CW'(1) : drop_cnt_q;
    end

    dvalid_d = (state_d == S_SEND);
    dout_d   = dvalid_d ? sreg_d[W-1:0] : '0;
    dlast_d  = dvalid_d && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sreg_q     <= '0;
      idx_q      <= '0;
      dout_q     <= '0;
      dvalid_q   <= 1'b0;
      dlast_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      idx_q      <= idx_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
      dlast_q    <= dlast_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage only; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign bus.dout   = dout_q;
  assign bus.dvalid = dvalid_q;
  assign bus.dlast  = dlast_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_toeplitz_outbuf.sv
// tb/tb_toeplitz_outbuf.sv - randomized and directed bench for toeplitz_outbuf
module tb_toeplitz_outbuf;
  localparam int L     = 128;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int NCH   = L / W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  level, level2;
  logic        overflow, overflow2;
  logic [15:0] drop_cnt;
  logic [3:0]  drop_cnt2;
  logic        clear_ovf, clear_ovf2;

  toeplitz_outbuf_if #(.L(L), .W(W)) bus ();
  toeplitz_outbuf_if #(.L(L), .W(W)) bus2 ();

  toeplitz_outbuf #(.L(L), .W(W), .DEPTH(DEPTH), .CW(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .level(level),
    .overflow(overflow), .drop_cnt(drop_cnt), .clear_ovf(clear_ovf)
  );

  toeplitz_outbuf #(.L(L), .W(W), .DEPTH(DEPTH), .CW(4)) dut_small (
    .clk(clk), .reset(reset), .bus(bus2), .level(level2),
    .overflow(overflow2), .drop_cnt(drop_cnt2), .clear_ovf(clear_ovf2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: words held = accepted minus fully emitted; capacity DEPTH+1.
  logic [8:0]  obs_q[$];
  logic [8:0]  exp_q[$];
  int          model_words;
  int          sent_cnt;
  logic [15:0] model_drops;
  logic        model_ovf;

  function automatic logic [L-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    obs_q.delete();
    exp_q.delete();
    model_words = 0;
    sent_cnt    = 0;
    model_drops = '0;
    model_ovf   = 1'b0;
  endtask

  // Called with outputs settled; the driven inputs act on the next rising edge.
  task automatic step(input bit strobe, input logic [L-1:0] w, input bit rdy, input bit clr);
    bit done;
    bit drop;
    done = 1'b0;
    drop = 1'b0;
    if (bus.dvalid && rdy) begin
      obs_q.push_back({bus.dlast, bus.dout});
      sent_cnt++;
      if (sent_cnt == NCH) begin
        sent_cnt = 0;
        done     = 1'b1;
      end
    end
    if (done) model_words--;
    if (strobe) begin
      if (model_words < DEPTH + 1) begin
        model_words++;
        for (int k = 0; k < NCH; k++) exp_q.push_back({k == NCH - 1, w[k*W +: W]});
      end else begin
        drop = 1'b1;
      end
    end
    if (clr) begin
      model_drops = drop ? 16'd1 : 16'd0;
      model_ovf   = drop;
    end else if (drop) begin
      model_ovf = 1'b1;
      if (model_drops != 16'hFFFF) model_drops++;
    end
    bus.q       = w;
    bus.qstrobe = strobe;
    bus.dready  = rdy;
    clear_ovf   = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (obs_q.size() >= exp_q.size() && !bus.dvalid) break;
      step(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset();
    n_tests += 6;
    if (bus.dout !== 8'h00)   begin n_fail++; $display("FAIL reset_dout got %h exp 00", bus.dout); end
    if (bus.dvalid !== 1'b0)  begin n_fail++; $display("FAIL reset_dvalid got %b exp 0", bus.dvalid); end
    if (bus.dlast !== 1'b0)   begin n_fail++; $display("FAIL reset_dlast got %b exp 0", bus.dlast); end
    if (level !== 3'd0)       begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
    if (overflow !== 1'b0)    begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    if (drop_cnt !== 16'd0)   begin n_fail++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
  endtask

  task automatic test_single();
    logic [L-1:0] w0;
    w0 = 128'h0F0E0D0C0B0A09080706050403020100;
    step(1'b1, w0, 1'b1, 1'b0);
    n_tests++;
    if (bus.dvalid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b exp 0", bus.dvalid); end
    step(1'b0, '0, 1'b1, 1'b0);
    n_tests++;
    if ({bus.dvalid, bus.dlast, bus.dout} !== {2'b10, 8'h00}) begin
      n_fail++; $display("FAIL single_latency got v%b l%b %h exp v1 l0 00", bus.dvalid, bus.dlast, bus.dout);
    end
    for (int i = 0; i < NCH; i++) step(1'b0, '0, 1'b1, 1'b0);
    n_tests += 3;
    if (obs_q.size() != NCH) begin n_fail++; $display("FAIL single_count got %0d exp 16", obs_q.size()); end
    if (bus.dvalid !== 1'b0) begin n_fail++; $display("FAIL single_tail_valid got %b exp 0", bus.dvalid); end
    if (level !== 3'd0)      begin n_fail++; $display("FAIL single_level got %0d exp 0", level); end
    for (int i = 0; i < obs_q.size() && i < NCH; i++) begin
      n_tests++;
      if (obs_q[i] !== {i == NCH - 1, 8'(i)}) begin
        n_fail++; $display("FAIL single_chunk%0d got %h exp %h", i, obs_q[i], {i == NCH - 1, 8'(i)});
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [L-1:0] w0;
    bit           held;
    logic [8:0]   held_v;
    w0 = 128'h0F0E0D0C0B0A09080706050403020100;
    for (int i = 0; i < 70; i++) begin
      bit rdy;
      rdy    = (i % 3 == 0);
      held   = bus.dvalid && !rdy;
      held_v = {bus.dlast, bus.dout};
      step(i == 0, w0, rdy, 1'b0);
      if (held) begin
        n_tests++;
        if (!(bus.dvalid === 1'b1 && {bus.dlast, bus.dout} === held_v)) begin
          n_fail++; $display("FAIL bp_hold cycle %0d got v%b %h exp v1 %h", i, bus.dvalid, {bus.dlast, bus.dout}, held_v);
        end
      end
    end
    n_tests += 2;
    if (obs_q.size() != NCH) begin n_fail++; $display("FAIL bp_count got %0d exp 16", obs_q.size()); end
    if (bus.dvalid !== 1'b0) begin n_fail++; $display("FAIL bp_tail_valid got %b exp 0", bus.dvalid); end
    for (int i = 0; i < obs_q.size() && i < NCH; i++) begin
      n_tests++;
      if (obs_q[i] !== {i == NCH - 1, 8'(i)}) begin
        n_fail++; $display("FAIL bp_chunk%0d got %h exp %h", i, obs_q[i], {i == NCH - 1, 8'(i)});
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [L-1:0] wa, wb;
    int first, last, nvalid, nlast;
    wa = rand_word();
    wb = rand_word();
    first = -1; last = -1; nvalid = 0; nlast = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      if (bus.dvalid) begin
        nvalid++;
        if (first < 0) first = cyc;
        last = cyc;
        if (bus.dlast) nlast++;
      end
      step(cyc == 0 || cyc == 2, (cyc == 0) ? wa : wb, 1'b1, 1'b0);
    end
    n_tests += 4;
    if (nvalid != 32)            begin n_fail++; $display("FAIL b2b_valid_cycles got %0d exp 32", nvalid); end
    if (last - first + 1 != 32)  begin n_fail++; $display("FAIL b2b_contiguous got %0d exp 32", last - first + 1); end
    if (first != 2)              begin n_fail++; $display("FAIL b2b_first got %0d exp 2", first); end
    if (nlast != 2)              begin n_fail++; $display("FAIL b2b_dlast got %0d exp 2", nlast); end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_len got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_chunk%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_overflow();
    logic [L-1:0] words [7];
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) words[i] = rand_word() ^ L'(i);
    for (int i = 0; i < 7; i++) step(1'b1, words[i], 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    n_tests += 4;
    if (level !== 3'd4)     begin n_fail++; $display("FAIL ovf_level got %0d exp 4", level); end
    if (overflow !== 1'b1)  begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_drop_cnt got %0d exp 2", drop_cnt); end
    if ({bus.dvalid, bus.dout} !== {1'b1, words[0][7:0]}) begin
      n_fail++; $display("FAIL ovf_head got v%b %h exp v1 %h", bus.dvalid, bus.dout, words[0][7:0]);
    end
    drain(200);
    n_tests++;
    if (obs_q.size() != 5 * NCH) begin n_fail++; $display("FAIL ovf_len got %0d exp 80", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 5 * NCH; i++) begin
      n_tests++;
      if (obs_q[i] !== {i % NCH == NCH - 1, words[i / NCH][(i % NCH)*W +: W]}) begin
        n_fail++; $display("FAIL ovf_chunk%0d got %h exp %h", i, obs_q[i], {i % NCH == NCH - 1, words[i / NCH][(i % NCH)*W +: W]});
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 5; i++) step(1'b1, rand_word(), 1'b0, 1'b0);
    step(1'b1, rand_word(), 1'b0, 1'b1);
    n_tests += 2;
    if (overflow !== 1'b1)  begin n_fail++; $display("FAIL clr_drop_flag got %b exp 1", overflow); end
    if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL clr_drop_cnt got %0d exp 1", drop_cnt); end
    step(1'b0, '0, 1'b0, 1'b1);
    n_tests += 2;
    if (overflow !== 1'b0)  begin n_fail++; $display("FAIL clr_flag got %b exp 0", overflow); end
    if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_cnt got %0d exp 0", drop_cnt); end
    drain(200);
    n_tests++;
    if (obs_q.size() != 5 * NCH) begin n_fail++; $display("FAIL clr_len got %0d exp 80", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL clr_chunk%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_saturation();
    bus2.dready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus2.q = rand_word(); bus2.qstrobe = 1'b1;
      @(posedge clk); #2;
    end
    n_tests += 2;
    if (drop_cnt2 !== 4'd0) begin n_fail++; $display("FAIL sat_initial got %0d exp 0", drop_cnt2); end
    if (level2 !== 3'd4)    begin n_fail++; $display("FAIL sat_level got %0d exp 4", level2); end
    for (int i = 0; i < 14; i++) begin
      bus2.q = rand_word(); @(posedge clk); #2;
    end
    n_tests++;
    if (drop_cnt2 !== 4'hE) begin n_fail++; $display("FAIL sat_14 got %h exp e", drop_cnt2); end
    @(posedge clk); #2;
    n_tests += 2;
    if (drop_cnt2 !== 4'hF) begin n_fail++; $display("FAIL sat_15 got %h exp f", drop_cnt2); end
    if (overflow2 !== 1'b1) begin n_fail++; $display("FAIL sat_flag got %b exp 1", overflow2); end
    repeat (4) begin @(posedge clk); #2; end
    n_tests++;
    if (drop_cnt2 !== 4'hF) begin n_fail++; $display("FAIL sat_hold got %h exp f", drop_cnt2); end
    bus2.qstrobe = 1'b0;
    clear_ovf2   = 1'b1;
    @(posedge clk); #2;
    clear_ovf2   = 1'b0;
    n_tests++;
    if ({overflow2, drop_cnt2} !== 5'd0) begin n_fail++; $display("FAIL sat_clear got %b/%h exp 0/0", overflow2, drop_cnt2); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      bit strobe, rdy, clr;
      strobe = (i < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      rdy    = (i < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      clr    = ($urandom_range(0, 60) == 0);
      step(strobe, rand_word(), rdy, clr);
      n_tests++;
      if (drop_cnt !== model_drops || overflow !== model_ovf) begin
        n_fail++; $display("FAIL rand_drops cycle %0d got %0d/%b exp %0d/%b", i, drop_cnt, overflow, model_drops, model_ovf);
      end
    end
    drain(800);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_len got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_chunk%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    logic [L-1:0] wd;
    for (int i = 0; i < 3; i++) step(1'b1, rand_word(), 1'b1, 1'b0);
    for (int i = 0; i < 20 && obs_q.size() < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
    n_tests++;
    if (obs_q.size() != 6) begin n_fail++; $display("FAIL arst_pre_count got %0d exp 6", obs_q.size()); end
    #1 reset = 1'b0;
    #1;
    n_tests += 4;
    if (bus.dvalid !== 1'b0) begin n_fail++; $display("FAIL arst_dvalid got %b exp 0", bus.dvalid); end
    if (level !== 3'd0)      begin n_fail++; $display("FAIL arst_level got %0d exp 0", level); end
    if (overflow !== 1'b0)   begin n_fail++; $display("FAIL arst_overflow got %b exp 0", overflow); end
    if (bus.dout !== 8'h00)  begin n_fail++; $display("FAIL arst_dout got %h exp 00", bus.dout); end
    #2 reset = 1'b1;
    model_reset();
    @(posedge clk); #2;
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
    n_tests += 2;
    if (obs_q.size() != 0)   begin n_fail++; $display("FAIL arst_residual got %0d exp 0", obs_q.size()); end
    if (bus.dvalid !== 1'b0) begin n_fail++; $display("FAIL arst_idle_valid got %b exp 0", bus.dvalid); end
    wd = rand_word();
    step(1'b1, wd, 1'b1, 1'b0);
    drain(40);
    n_tests += 2;
    if (obs_q.size() != NCH) begin n_fail++; $display("FAIL arst_len got %0d exp 16", obs_q.size()); end
    if (obs_q.size() > 0 && obs_q[0] !== {1'b0, wd[7:0]}) begin
      n_fail++; $display("FAIL arst_first got %h exp %h", obs_q[0], {1'b0, wd[7:0]});
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL arst_chunk%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    bus.q        = '0;
    bus.qstrobe  = 1'b0;
    bus.dready   = 1'b0;
    clear_ovf    = 1'b0;
    bus2.q       = '0;
    bus2.qstrobe = 1'b0;
    bus2.dready  = 1'b0;
    clear_ovf2   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_clear();
    test_saturation();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
